result_fifo: RTL and testbench
==============================

RESULT_FIFO -- requirements
Module: result_fifo

Interface
REQ-001 Parameter: WIDTH, 3, data width of buffered results.
REQ-002 Parameter: DEPTH, 4, number of entries; SHALL be a power of two and at least 2.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in_data  input  WIDTH  result word from upstream arithmetic stage (its f output).
REQ-006 Port: in_valid  input  1  in_data valid this cycle.
REQ-007 Port: in_ready  output  1  buffer can accept a word; equals !full.
REQ-008 Port: out_data  output  WIDTH  head entry, first-word fall-through.
REQ-009 Port: out_valid  output  1  head entry valid; equals !empty.
REQ-010 Port: out_ready  input  1  consumer takes head this cycle.
REQ-011 Port: count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 Port: full, empty  output  1 each  occupancy flags.
REQ-013 Port: overflow  output  1  sticky: a write was attempted while full.

Function
REQ-014 Push SHALL occur on an edge where in_valid && !full; word written at wr_ptr, wr_ptr increments.
REQ-015 Pop SHALL occur on an edge where out_ready && !empty; rd_ptr increments.
REQ-016 Pointers SHALL wrap modulo DEPTH with no gap or repeated entry.
REQ-017 out_data SHALL be combinational from mem[rd_ptr]; value is don't-care when empty.
REQ-018 Push-to-out_valid latency SHALL be exactly 1 cycle; no bypass path from in_data to out_data.
REQ-019 Simultaneous push and pop with 0 < count < DEPTH: both take effect, count unchanged.
REQ-020 Full: in_ready low; an in_valid word SHALL be dropped, no state except overflow changes, even if out_ready pops in the same cycle.
REQ-021 Empty: out_ready SHALL be ignored; count never underflows.
REQ-022 overflow SHALL set on the edge of a dropped write and hold until reset.
REQ-023 full = (count == DEPTH); empty = (count == 0); both derived from registered count.

Reset
REQ-024 reset asserted SHALL immediately clear wr_ptr, rd_ptr, count, overflow (and statistics); empty=1, full=0, out_valid=0, in_ready=1.
REQ-025 Memory contents SHALL NOT be reset; reset mid-operation discards all stored words.
REQ-026 First push SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro RESULT_FIFO_STATS_EN defined: extra outputs pop_sum (8 bits, saturating at 255, adds out_data on every pop) and pop_cnt (8 bits, wraps at 256).
REQ-028 Macro undefined: pop_sum and pop_cnt ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Shared package result_pkg SHALL hold RESULT_W (3), FIFO_DEPTH (4), and typedef result_t (logic [RESULT_W-1:0]).
REQ-030 Storage SHALL be one sub-module result_fifo_mem (DEPTH x WIDTH, one write port, one async read port); pointer/count control stays in result_fifo.

Verification
REQ-031 Reset held 2 cycles, then released -> empty=1, count=0, in_ready=1, overflow=0.
REQ-032 Push 5,2,7,3 on consecutive cycles -> count=4, full=1, in_ready=0; out_data=5 one cycle after first push.
REQ-033 While full, push 1 -> word dropped, overflow=1 (sticky); popping 4 times yields 5,2,7,3, then empty=1.
REQ-034 Count=2, push 6 and pop together for 3 cycles -> count stays 2, output order preserved, pointers wrap past entry 3 correctly.
REQ-035 Reset asserted mid-stream with count=3 -> outputs return to reset values the same cycle, without waiting for a clock edge; subsequent push 4 pops as 4.
REQ-036 RESULT_FIFO_STATS_EN: pops of 5,2,7,3 -> pop_sum=17, pop_cnt=4; 40 pops of 7 -> pop_sum saturates at 255.

Source files
------------

// File: rtl/result_pkg.sv
// Shared widths and types for the result buffer and its consumers.
package result_pkg;
    localparam int RESULT_W   = 3;
    localparam int FIFO_DEPTH = 4;

    typedef logic [RESULT_W-1:0] result_t;
endpackage

// File: rtl/result_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module result_fifo_mem #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/result_fifo.sv
// First-word fall-through result buffer with sticky overflow flag.
// Define RESULT_FIFO_STATS_EN to add pop_sum / pop_cnt statistics outputs.
module result_fifo
    import result_pkg::*;
#(
    parameter int WIDTH = RESULT_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
`ifdef RESULT_FIFO_STATS_EN
    output logic [7:0]                 pop_sum,
    output logic [7:0]                 pop_cnt,
`endif
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;
    assign overflow  = overflow_q;

    // A dropped write freezes the whole buffer for that edge, including a pop.
    assign push = in_valid && !full;
    assign pop  = out_ready && !empty && !(in_valid && full);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (in_valid && full);
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    result_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (out_data)
    );

`ifdef RESULT_FIFO_STATS_EN
    logic [7:0] pop_sum_q, pop_sum_d, pop_cnt_q, pop_cnt_d;
    logic [8:0] sum_ext;

    always_comb begin
        sum_ext   = {1'b0, pop_sum_q} + 9'(out_data);
        pop_sum_d = pop_sum_q;
        pop_cnt_d = pop_cnt_q;
        if (pop) begin
            pop_sum_d = sum_ext[8] ? 8'hFF : sum_ext[7:0];
            pop_cnt_d = pop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_sum_q <= '0;
            pop_cnt_q <= '0;
        end else begin
            pop_sum_q <= pop_sum_d;
            pop_cnt_q <= pop_cnt_d;
        end
    end

    assign pop_sum = pop_sum_q;
    assign pop_cnt = pop_cnt_q;
`endif
endmodule

// File: tb/tb_result_fifo.sv
// Directed vector bench for result_fifo; stats checks compile in with RESULT_FIFO_STATS_EN.
module tb_result_fifo;
    import result_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    result_t    in_data;
    logic       in_valid, in_ready;
    result_t    out_data;
    logic       out_valid, out_ready;
    logic [2:0] count;
    logic       full, empty, overflow;
`ifdef RESULT_FIFO_STATS_EN
    logic [7:0] pop_sum, pop_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    result_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
`ifdef RESULT_FIFO_STATS_EN
        .pop_sum   (pop_sum),
        .pop_cnt   (pop_cnt),
`endif
        .overflow  (overflow)
    );

    typedef struct {
        logic    iv;
        result_t d;
        logic    ordy;
        int      cnt;
        logic    vld;
        result_t dat;
        logic    ovf;
        string   nm;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, int d, logic ordy, int cnt, logic vld, int dat,
                                logic ovf, string nm);
        vec_t v;
        v.iv = iv; v.d = result_t'(d); v.ordy = ordy; v.cnt = cnt;
        v.vld = vld; v.dat = result_t'(dat); v.ovf = ovf; v.nm = nm;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_state(string nm, int cnt, logic vld, int dat, logic ovf);
        chk({nm, ".count"},     int'(count), cnt);
        chk({nm, ".out_valid"}, int'(out_valid), int'(vld));
        chk({nm, ".empty"},     int'(empty), int'(cnt == 0));
        chk({nm, ".full"},      int'(full), int'(cnt == 4));
        chk({nm, ".in_ready"},  int'(in_ready), int'(cnt != 4));
        chk({nm, ".overflow"},  int'(overflow), int'(ovf));
        if (vld) chk({nm, ".out_data"}, int'(out_data), dat);
    endtask

    task automatic step(logic iv, int d, logic ordy);
        in_valid  = iv;
        in_data   = result_t'(d);
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_state("reset", 0, 1'b0, 0, 1'b0);

        // fill, overflow attempts, drain in order
        tbl.push_back(mk(1, 5, 0, 1, 1, 5, 0, "push5"));
        tbl.push_back(mk(1, 2, 0, 2, 1, 5, 0, "push2"));
        tbl.push_back(mk(1, 7, 0, 3, 1, 5, 0, "push7"));
        tbl.push_back(mk(1, 3, 0, 4, 1, 5, 0, "push3_full"));
        tbl.push_back(mk(1, 1, 0, 4, 1, 5, 1, "drop1"));
        tbl.push_back(mk(1, 1, 1, 4, 1, 5, 1, "drop1_with_pop"));
        tbl.push_back(mk(0, 0, 1, 3, 1, 2, 1, "pop5"));
        tbl.push_back(mk(0, 0, 1, 2, 1, 7, 1, "pop2"));
        tbl.push_back(mk(0, 0, 1, 1, 1, 3, 1, "pop7"));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, "pop3_empty"));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, "pop_when_empty"));
        tbl.push_back(mk(1, 2, 1, 1, 1, 2, 1, "push_pop_empty"));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, "pop2b"));
        // count=2 then concurrent push/pop across the pointer wrap
        tbl.push_back(mk(1, 1, 0, 1, 1, 1, 1, "push1"));
        tbl.push_back(mk(1, 4, 0, 2, 1, 1, 1, "push4"));
        tbl.push_back(mk(1, 6, 1, 2, 1, 4, 1, "pp6"));
        tbl.push_back(mk(1, 5, 1, 2, 1, 6, 1, "pp5"));
        tbl.push_back(mk(1, 4, 1, 2, 1, 5, 1, "pp4_wrap"));
        tbl.push_back(mk(0, 0, 1, 1, 1, 4, 1, "pop_after_wrap"));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, "pop_last"));
        tbl.push_back(mk(1, 1, 0, 1, 1, 1, 1, "refill1"));
        tbl.push_back(mk(1, 2, 0, 2, 1, 1, 1, "refill2"));
        tbl.push_back(mk(1, 3, 0, 3, 1, 1, 1, "refill3"));

        foreach (tbl[i]) begin
            step(tbl[i].iv, int'(tbl[i].d), tbl[i].ordy);
            chk_state(tbl[i].nm, tbl[i].cnt, tbl[i].vld, int'(tbl[i].dat), tbl[i].ovf);
        end

        // asynchronous reset mid-cycle with count=3: outputs clear before any edge
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_state("async_reset", 0, 1'b0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 4, 0);
        chk_state("post_reset_push4", 1, 1'b1, 4, 1'b0);
        step(0, 0, 1);
        chk_state("post_reset_pop4", 0, 1'b0, 0, 1'b0);

`ifdef RESULT_FIFO_STATS_EN
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("stats_reset.pop_sum", int'(pop_sum), 0);
        chk("stats_reset.pop_cnt", int'(pop_cnt), 0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 5, 0); step(1, 2, 0); step(1, 7, 0); step(1, 3, 0);
        repeat (4) step(0, 0, 1);
        chk("stats_4.pop_sum", int'(pop_sum), 17);
        chk("stats_4.pop_cnt", int'(pop_cnt), 4);
        for (int k = 0; k < 40; k++) begin
            step(1, 7, 0);
            step(0, 0, 1);
        end
        chk("stats_sat.pop_sum", int'(pop_sum), 255);
        chk("stats_sat.pop_cnt", int'(pop_cnt), 44);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
